// File: rtl/mmio_router.sv
// MMIO router: one master to NCH slaves, with per-channel wait states
// and an error response for unmapped channels.
module mmio_router #(
   parameter int NCH = 3,
   parameter int AW = 12,
   parameter int DW = 16,
   parameter int DECODE = 0,
   parameter logic [4*NCH-1:0] WAITS = '0,
   localparam int CW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              wren,
   input  logic [AW-1:0]     addr,
   input  logic [DW-1:0]     data,
   input  logic [CW-1:0]     sel,
   output logic              ack,
   output logic              err,
   output logic [DW-1:0]     rdata,
   output logic              busy,
   output logic [AW-1:0]     s_addr,
   output logic [DW-1:0]     s_data,
   output logic [NCH-1:0]    s_wren,
   input  logic [NCH*DW-1:0] s_q
);

   localparam int NS = 2**CW;
   localparam logic [CW:0] NCH_V = (CW+1)'(NCH);

   typedef enum logic [1:0] {IDLE, ACCESS, ACK_S} state_t;

   state_t         state;
   logic [CW-1:0]  ch;
   logic [CW-1:0]  ch_in;
   logic [3:0]     cnt;
   logic           wr_q;
   logic           hit;
   logic [NCH-1:0] one_hot;
   logic [3:0]     wait_a [NS];
   logic [DW-1:0]  q_a [NS];

   // Unmapped slots read as zero wait and zero data; never reached.
   for (genvar k = 0; k < NS; k++) begin : g_ch
      if (k < NCH) begin : g_map
         assign wait_a[k] = WAITS[4*k +: 4];
         assign q_a[k]    = s_q[DW*k +: DW];
      end else begin : g_unmap
         assign wait_a[k] = '0;
         assign q_a[k]    = '0;
      end
   end

   if (DECODE != 0) begin : g_dec
      logic unused_sel;
      assign unused_sel = ^sel;
      assign ch_in = addr[AW-1 -: CW];
   end else begin : g_sel
      assign ch_in = sel;
   end

   assign hit     = {1'b0, ch_in} < NCH_V;
   assign one_hot = NCH'(1) << ch_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         ch     <= '0;
         wr_q   <= 1'b0;
         ack    <= 1'b0;
         err    <= 1'b0;
         busy   <= 1'b0;
         s_wren <= '0;
         rdata  <= '0;
         s_addr <= '0;
         s_data <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req) begin
                  s_addr <= addr;
                  s_data <= data;
                  wr_q   <= wren;
                  ch     <= ch_in;
                  busy   <= 1'b1;
                  if (hit) begin
                     state  <= ACCESS;
                     cnt    <= wait_a[ch_in];
                     s_wren <= wren ? one_hot : '0;
                  end else begin
                     state <= ACK_S;
                     ack   <= 1'b1;
                     err   <= 1'b1;
                     rdata <= '0;
                  end
               end
            end
            ACCESS: begin
               // Strobe lives only in the first access cycle.
               s_wren <= '0;
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= ACK_S;
                  ack   <= 1'b1;
                  if (!wr_q) rdata <= q_a[ch];
               end
            end
            ACK_S: begin
               state <= IDLE;
               ack   <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_router.sv
// Scoreboard bench for mmio_router: select-mode and address-decode
// instances driven with random traffic against a transaction model.
module tb_mmio_router;

   typedef struct {
      int          d;
      int          cyc;
      logic        err;
      logic [15:0] rdata;
   } ack_t;

   typedef struct {
      int          d;
      int          cyc;
      logic [3:0]  vec;
      logic [11:0] a;
      logic [15:0] dt;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req [2];
   logic        wren [2];
   logic [11:0] addr [2];
   logic [15:0] data [2];
   logic [1:0]  sel [2];
   logic        ack [2];
   logic        err [2];
   logic        busy [2];
   logic [15:0] rdata [2];
   logic [11:0] s_addr [2];
   logic [15:0] s_data [2];
   logic [3:0]  s_wren [2];
   logic [2:0]  sw0;
   logic [3:0]  sw1;
   logic [47:0] sq0;
   logic [63:0] sq1;

   int nchk = 0;
   int nerr = 0;
   int cyc = 0;
   int bs [2] = '{1, 1};
   int be [2] = '{0, 0};
   logic [15:0] last_rd [2] = '{16'h0, 16'h0};
   int waits0 [3] = '{5, 0, 3};
   int waits1 [4] = '{2, 0, 1, 15};
   ack_t aq [$];
   wr_t  wq [$];

   assign s_wren[0] = {1'b0, sw0};
   assign s_wren[1] = sw1;

   mmio_router #(.NCH(3), .AW(12), .DW(16), .DECODE(0),
                 .WAITS(12'h305)) u0 (
      .clk(clk), .rst(rst), .req(req[0]), .wren(wren[0]),
      .addr(addr[0]), .data(data[0]), .sel(sel[0]),
      .ack(ack[0]), .err(err[0]), .rdata(rdata[0]), .busy(busy[0]),
      .s_addr(s_addr[0]), .s_data(s_data[0]), .s_wren(sw0), .s_q(sq0)
   );

   mmio_router #(.NCH(4), .AW(12), .DW(16), .DECODE(1),
                 .WAITS(16'hF102)) u1 (
      .clk(clk), .rst(rst), .req(req[1]), .wren(wren[1]),
      .addr(addr[1]), .data(data[1]), .sel(sel[1]),
      .ack(ack[1]), .err(err[1]), .rdata(rdata[1]), .busy(busy[1]),
      .s_addr(s_addr[1]), .s_data(s_data[1]), .s_wren(sw1), .s_q(sq1)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic chk_zero(int d);
      chk("rst_ack", ack[d], 0);
      chk("rst_err", err[d], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_swren", s_wren[d], 0);
      chk("rst_rdata", rdata[d], 0);
      chk("rst_saddr", s_addr[d], 0);
      chk("rst_sdata", s_data[d], 0);
   endtask

   task automatic scramble(int d);
      wren[d] = 1'($urandom);
      addr[d] = 12'($urandom);
      data[d] = 16'($urandom);
      sel[d]  = 2'($urandom);
   endtask

   // Called at a negedge with the DUT able to accept on the next edge.
   task automatic txn(int d, logic w, logic [11:0] a, logic [15:0] dt,
                      logic [1:0] s, logic [15:0] qv, int gap, bit hold);
      int   ch, wt, acc, len;
      bit   e;
      ack_t ai;
      wr_t  wi;
      ch = (d == 1) ? int'(a[11:10]) : int'(s);
      e  = ch >= ((d == 1) ? 4 : 3);
      wt = 0;
      if (!e) wt = (d == 1) ? waits1[ch] : waits0[ch];
      if (d == 0) begin
         sq0 = 48'({$urandom, $urandom});
         if (!e) sq0[16*ch +: 16] = qv;
      end else begin
         sq1 = {$urandom, $urandom};
         sq1[16*ch +: 16] = qv;
      end
      req[d]  = 1'b1;
      wren[d] = w;
      addr[d] = a;
      data[d] = dt;
      sel[d]  = s;
      acc = cyc + 1;
      if (e) last_rd[d] = 16'h0;
      else if (!w) last_rd[d] = qv;
      ai.d     = d;
      ai.cyc   = e ? acc : acc + wt + 1;
      ai.err   = e;
      ai.rdata = last_rd[d];
      aq.push_back(ai);
      if (!e && w) begin
         wi.d   = d;
         wi.cyc = acc;
         wi.vec = 4'(1 << ch);
         wi.a   = a;
         wi.dt  = dt;
         wq.push_back(wi);
      end
      bs[d] = acc;
      be[d] = ai.cyc;
      len = e ? 2 : wt + 3;
      @(posedge clk);
      for (int i = 1; i < len; i++) begin
         @(negedge clk);
         req[d] = hold | 1'($urandom);
         scramble(d);
         @(posedge clk);
      end
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         req[d] = 1'b0;
         scramble(d);
         @(posedge clk);
      end
      @(negedge clk);
      req[d] = 1'b0;
   endtask

   // Write on a 5-wait channel, aborted by reset two edges in.
   task automatic rst_mid();
      int   acc;
      wr_t  wi;
      req[0]  = 1'b1;
      wren[0] = 1'b1;
      sel[0]  = 2'd0;
      addr[0] = 12'h3A5;
      data[0] = 16'h5A5A;
      acc = cyc + 1;
      wi.d   = 0;
      wi.cyc = acc;
      wi.vec = 4'b0001;
      wi.a   = 12'h3A5;
      wi.dt  = 16'h5A5A;
      wq.push_back(wi);
      bs[0] = acc;
      be[0] = acc + 100;
      @(posedge clk);
      @(negedge clk);
      req[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      be[0] = cyc;
      last_rd[0] = 16'h0;
      last_rd[1] = 16'h0;
      #1 chk_zero(0);
      chk_zero(1);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      ack_t ai;
      wr_t  wi;
      if (rst === 1'b0) begin
         for (int d = 0; d < 2; d++) begin
            chk("busy", busy[d], (cyc >= bs[d] && cyc <= be[d]));
            if (ack[d] !== 1'b1) chk("err_no_ack", err[d], 0);
            if (ack[d] === 1'b1) begin
               chk("ack_expected", aq.size() != 0, 1);
               if (aq.size() != 0) begin
                  ai = aq.pop_front();
                  chk("ack_dut", d, ai.d);
                  chk("ack_cyc", cyc, ai.cyc);
                  chk("ack_err", err[d], ai.err);
                  chk("rdata", rdata[d], ai.rdata);
               end
            end
            if (s_wren[d] !== 4'b0) begin
               chk("swren_expected", wq.size() != 0, 1);
               if (wq.size() != 0) begin
                  wi = wq.pop_front();
                  chk("swren_dut", d, wi.d);
                  chk("swren_cyc", cyc, wi.cyc);
                  chk("swren_vec", s_wren[d], wi.vec);
                  chk("s_addr", s_addr[d], wi.a);
                  chk("s_data", s_data[d], wi.dt);
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      sq0 = '0;
      sq1 = '0;
      for (int d = 0; d < 2; d++) begin
         req[d]  = 1'b0;
         wren[d] = 1'b0;
         addr[d] = '0;
         data[d] = '0;
         sel[d]  = '0;
      end
      #1 rst = 1'b1;
      #1 chk_zero(0);
      chk_zero(1);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);

      txn(0, 1'b0, 12'h010, 16'h0000, 2'd1, 16'hBEEF, 0, 1'b0);
      txn(0, 1'b1, 12'h005, 16'h1234, 2'd2, 16'h7777, 1, 1'b0);
      txn(0, 1'b0, 12'h0AA, 16'h4321, 2'd3, 16'h9999, 0, 1'b0);
      for (int i = 0; i < 4; i++)
         txn(0, 1'b0, 12'($urandom), 16'($urandom), 2'd1,
             16'($urandom), 0, 1'b1);
      rst_mid();
      txn(0, 1'b0, 12'h123, 16'h0, 2'd2, 16'hA5C3, 0, 1'b0);
      for (int i = 0; i < 40; i++)
         txn(0, 1'($urandom), 12'($urandom), 16'($urandom),
             2'($urandom), 16'($urandom), $urandom_range(0, 2),
             1'($urandom));

      txn(1, 1'b0, 12'hC10, 16'h0, 2'd0, 16'hCAFE, 0, 1'b0);
      txn(1, 1'b1, 12'hC44, 16'hF00D, 2'd1, 16'h1111, 0, 1'b0);
      for (int i = 0; i < 30; i++)
         txn(1, 1'($urandom), 12'($urandom), 16'($urandom),
             2'($urandom), 16'($urandom), $urandom_range(0, 2),
             1'($urandom));

      repeat (5) @(negedge clk);
      chk("ack_queue_drained", aq.size(), 0);
      chk("swren_queue_drained", wq.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
